// File: rtl/scoreboard_page_ctrl.sv
// Page sequencer and 4-digit display scanner for the scoreboard.
// Rotates the 4:1 page mux select through enabled pages on a dwell timer
// (with hold and manual advance) and scans the selected 16-bit BCD value
// onto a common-anode 7-segment display with leading-zero blanking.
module scoreboard_page_ctrl #(
    parameter int unsigned DWELL_CYCLES   = 50000000,
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  page_en,
    input  logic        hold,
    input  logic        next,
    output logic [1:0]  mux_sel,
    input  logic [15:0] mux_data,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        page_change
);

    localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
    localparam int unsigned RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

    logic [DW_W-1:0] r_dwell_cnt;
    logic [RF_W-1:0] r_refresh_cnt;
    logic [1:0]      r_mux_sel;
    logic [1:0]      r_digit_idx;
    logic [3:0]      r_an;
    logic [3:0]      r_digit;
    logic            r_page_change;

    logic            w_any_en;
    logic            w_expire;
    logic            w_skip;
    logic            w_adv;
    logic [1:0]      w_next_sel;
    logic [1:0]      w_cand;
    logic [15:0]     w_upper;
    logic            w_blank;

    // Advance decision: expiry, manual next or forced skip off a disabled
    // page all collapse into a single one-step advance.
    assign w_any_en = |page_en;
    assign w_expire = (r_dwell_cnt == DW_LAST) && !hold;
    assign w_skip   = w_any_en && !page_en[r_mux_sel];
    assign w_adv    = w_any_en && (w_expire || next || w_skip);

    // Nearest enabled page after the current one, searched with wrap-around;
    // farthest candidate first so the nearest one wins.
    always_comb begin
        w_next_sel = r_mux_sel;
        w_cand     = r_mux_sel;
        for (int k = 3; k >= 1; k--) begin
            w_cand = r_mux_sel + 2'(k);
            if (page_en[w_cand]) begin
                w_next_sel = w_cand;
            end
        end
    end

    // Dwell timer: frozen by hold, restarted by any advance, free-wrapping otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell_cnt <= '0;
        end else if (w_adv) begin
            r_dwell_cnt <= '0;
        end else if (!hold) begin
            if (r_dwell_cnt == DW_LAST) begin
                r_dwell_cnt <= '0;
            end else begin
                r_dwell_cnt <= r_dwell_cnt + DW_W'(1);
            end
        end
    end

    // Page select and its change strobe; with no page enabled the select parks at 0 silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux_sel     <= 2'd0;
            r_page_change <= 1'b0;
        end else if (!w_any_en) begin
            r_mux_sel     <= 2'd0;
            r_page_change <= 1'b0;
        end else begin
            if (w_adv) begin
                r_mux_sel <= w_next_sel;
            end
            r_page_change <= w_adv && (w_next_sel != r_mux_sel);
        end
    end

    // Digit scan timer; runs continuously and is never restarted by page changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
        end else if (r_refresh_cnt == RF_LAST) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RF_W'(1);
        end
    end

    // Nibbles from the current digit upward; all zero means a leading zero.
    assign w_upper = mux_data >> {r_digit_idx, 2'b00};
    assign w_blank = (r_digit_idx != 2'd0) && (w_upper == 16'd0);

    // Registered display drive: nibble for the scanned digit and its active-low enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an    <= 4'b1110;
            r_digit <= 4'd0;
        end else begin
            r_digit <= w_upper[3:0];
            r_an    <= w_blank ? 4'b1111 : ~(4'b0001 << r_digit_idx);
        end
    end

    assign mux_sel     = r_mux_sel;
    assign an          = r_an;
    assign digit       = r_digit;
    assign page_change = r_page_change;

endmodule

// File: doc/scoreboard_page_ctrl.md
Name: scoreboard_page_ctrl

Overview:
- Sequencer for the scoreboard's 4:1 16-bit page mux. Sources: score, combo, max combo, accuracy, each as 4 BCD nibbles.
- Rotates the mux select through enabled pages on a dwell timer, with hold and manual advance.
- Multiplexes the selected 16-bit value onto a 4-digit common-anode 7-segment display (digit scan plus leading-zero blanking).
- Sits between the game score registers/mux and the seven-segment decoder.

Parameters:
- DWELL_CYCLES, 50000000, clock cycles each page is shown before auto-advance (minimum 2).
- REFRESH_CYCLES, 50000, clock cycles each digit is driven before moving to the next (minimum 1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- page_en  in  4  bit i set = page i participates in rotation
- hold  in  1  level; freezes the dwell timer
- next  in  1  single-cycle pulse; advance page immediately
- mux_sel  out  2  drives the page mux select S
- mux_data  in  16  page mux output O (nibble k = digit k, digit 0 = least significant)
- an  out  4  active-low digit enables
- digit  out  4  BCD nibble for the currently enabled digit
- page_change  out  1  one-cycle pulse when mux_sel changes

Behaviour:
- Reset (rst=1 at clk edge):
  - mux_sel=0, dwell_cnt=0, refresh_cnt=0, digit_idx=0.
  - an=4'b1110, digit=0, page_change=0.
  - Reset mid-rotation or mid-scan abandons all state the same way.
- Dwell timer:
  - dwell_cnt increments each cycle when hold=0; holds its value when hold=1.
  - Expiry = (dwell_cnt==DWELL_CYCLES-1) and hold=0.
- Advance event: expiry, OR next=1 (next overrides hold), OR forced skip (page_en!=0 and page_en[mux_sel]==0; also ignores hold).
- On an advance event:
  - dwell_cnt<=0.
  - mux_sel<=first enabled index searching mux_sel+1, +2, +3 mod 4 (wrap 3->0).
  - If no other page is enabled, mux_sel is unchanged.
- page_change:
  - Registered; high exactly in the cycle where the new mux_sel is first visible.
  - Stays 0 if mux_sel did not actually change.
- page_en==0:
  - mux_sel<=0, no advances, page_change stays 0.
  - dwell_cnt still runs and wraps.
- Simultaneous events: next together with expiry (or with forced skip) produce one advance only, never a two-page step.
- Digit scan:
  - refresh_cnt runs every cycle, independent of hold and page changes.
  - At refresh_cnt==REFRESH_CYCLES-1: refresh_cnt<=0 and digit_idx<=digit_idx+1 mod 4.
  - Scan is not restarted on a page change.
- Outputs are registered, one-cycle latency from digit_idx/mux_data:
  - digit<=mux_data[4*idx+3 : 4*idx].
  - an<=~(4'b0001<<idx).
- Leading-zero blanking:
  - For idx>0, if every nibble idx..3 of mux_data is 0, then an<=4'b1111 (digit still loaded).
  - Digit 0 is never blanked, so value 0 shows "0".
- mux_data nibbles >9: passed through unchanged; decoder's problem.

Test Plan:
- Bench parameters: DWELL_CYCLES=8, REFRESH_CYCLES=2 unless stated.
- Reset then page_en=4'b1111, hold=0, run 40 cycles -> mux_sel steps 0,1,2,3,0 every 8 cycles; one page_change pulse per step; after rst, an=4'b1110, digit=0.
- page_en=4'b1010 from reset -> forced skip to 1 the cycle after reset release (page_change=1), then 3,1,3 every 8 cycles; clearing page_en[3] while sel=3 -> sel=1 next cycle regardless of hold.
- hold=1 for 20 cycles, then next pulse -> mux_sel constant during hold; advances one page 1 cycle after next; dwell restarts from 0 (next expiry 8 cycles later). Next coincident with expiry -> single step only.
- page_en=4'b0100 with sel=2 -> no sel change, page_change stays 0 over 30 cycles. page_en=0 -> sel=0, no pulses.
- mux_data=16'h1234, REFRESH_CYCLES=1 -> (an, digit) sequence (1110,4), (1101,3), (1011,2), (0111,1) repeating, each one cycle after idx.
- Blanking: mux_data=16'h0050 -> digit 1 shows 5, digits 2 and 3 an=1111. mux_data=16'h0000 -> only digit 0 lit with 0.
- Assert rst while sel=2, idx=3 -> next cycle all outputs at reset values.
